// File: rtl/seq_detector_moore_param.sv
// Moore-style serial pattern detector with a runtime-programmable pattern, length and
// overlap mode, a sample-enable qualifier, and a saturating match counter.
module seq_detector_moore_param #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic               sequence_in,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   pattern_len,
   input  logic               overlap_en,
   input  logic               clear_count,
   output logic               detector_out,
   output logic [CNT_W-1:0]   match_count
);

   typedef enum logic [1:0] {DISABLED, FILL, ARMED} state_t;

   state_t             state;
   logic [MAX_LEN-1:0] hist_reg, hist_next, hist_shift, mask;
   logic [LEN_W-1:0]   fill_reg, fill_next, fill_inc;
   logic [MAX_LEN-1:0] cfg_pattern_reg, cfg_pattern_next;
   logic [LEN_W-1:0]   cfg_len_reg, cfg_len_next;
   logic               cfg_overlap_reg, cfg_overlap_next;
   logic               det_reg, det_next;
   logic [CNT_W-1:0]   count_reg, count_next;
   logic               match;

   // Only the low cfg_len history bits take part in the comparison.
   for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign mask[gi] = (LEN_W'(gi) < cfg_len_reg);
   end

   assign hist_shift = {hist_reg[MAX_LEN-2:0], sequence_in};
   assign fill_inc   = (fill_reg < cfg_len_reg) ? fill_reg + 1'b1 : fill_reg;

   always_comb begin
      if (cfg_len_reg == '0)
         state = DISABLED;
      else if (fill_reg < cfg_len_reg)
         state = FILL;
      else
         state = ARMED;
   end

   always_comb begin
      hist_next        = hist_reg;
      fill_next        = fill_reg;
      cfg_pattern_next = cfg_pattern_reg;
      cfg_len_next     = cfg_len_reg;
      cfg_overlap_next = cfg_overlap_reg;
      match            = 1'b0;

      if (cfg_load) begin
         cfg_pattern_next = pattern;
         cfg_len_next     = (pattern_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pattern_len;
         cfg_overlap_next = overlap_en;
         hist_next        = '0;
         fill_next        = '0;
      end else begin
         case (state)
            FILL, ARMED: begin
               if (enable) begin
                  hist_next = hist_shift;
                  match     = (fill_inc >= cfg_len_reg) &&
                              (((hist_shift ^ cfg_pattern_reg) & mask) == '0);
                  // Without overlap the next occurrence must be built from fresh bits.
                  fill_next = (match && !cfg_overlap_reg) ? '0 : fill_inc;
               end
            end
            default: ;
         endcase
      end

      det_next = match;

      if (clear_count)
         count_next = '0;
      else if (match && (count_reg != {CNT_W{1'b1}}))
         count_next = count_reg + 1'b1;
      else
         count_next = count_reg;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hist_reg        <= '0;
         fill_reg        <= '0;
         cfg_pattern_reg <= '0;
         cfg_len_reg     <= '0;
         cfg_overlap_reg <= 1'b0;
         det_reg         <= 1'b0;
         count_reg       <= '0;
      end else begin
         hist_reg        <= hist_next;
         fill_reg        <= fill_next;
         cfg_pattern_reg <= cfg_pattern_next;
         cfg_len_reg     <= cfg_len_next;
         cfg_overlap_reg <= cfg_overlap_next;
         det_reg         <= det_next;
         count_reg       <= count_next;
      end
   end

   assign detector_out = det_reg;
   assign match_count  = count_reg;

endmodule
